// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: stage FSM states and occupancy width.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } pipeStateT;

endpackage

// File: rtl/pipe_slot.sv
// One payload register plus its valid bit; flush clears valid and optionally the payload.
module pipe_slot #(
    parameter int DATA_W         = 32,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              drop,
    input  logic [DATA_W-1:0] loadData,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            if (CLEAR_ON_FLUSH) begin
                data <= '0;
            end
        end else if (load) begin
            valid <= 1'b1;
            data  <= loadData;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with stall and flush.
// Define PIPE_STAGE_SKID_EN to add a skid slot and a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    pipeStateT         stateReg, stateNext;
    logic              inFire, outFire;
    logic              mainValid, mainLoad, mainDrop;
    logic [DATA_W-1:0] mainLoadData;

    assign out_valid = mainValid & ~stall;
    assign inFire    = in_valid & in_ready;
    assign outFire   = out_valid & out_ready;

    pipe_slot #(.DATA_W(DATA_W), .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)) mainSlot (
        .clk(clk), .rst(rst), .flush(flush),
        .load(mainLoad), .drop(mainDrop), .loadData(mainLoadData),
        .valid(mainValid), .data(out_data)
    );

`ifdef PIPE_STAGE_SKID_EN
    logic              skidValid, skidLoad, skidDrop;
    logic [DATA_W-1:0] skidData;

    // Only registered state here, so out_ready never reaches in_ready.
    assign in_ready  = ~rst & ~stall & ~skidValid;
    assign occupancy = {1'b0, mainValid} + {1'b0, skidValid};

    always_comb begin
        stateNext    = stateReg;
        mainLoad     = 1'b0;
        mainDrop     = 1'b0;
        mainLoadData = in_data;
        skidLoad     = 1'b0;
        skidDrop     = 1'b0;
        case (stateReg)
            PS_EMPTY: begin
                if (inFire) begin
                    mainLoad  = 1'b1;
                    stateNext = PS_FULL;
                end
            end
            PS_FULL: begin
                if (inFire && outFire) begin
                    mainLoad = 1'b1;
                end else if (inFire) begin
                    skidLoad  = 1'b1;
                    stateNext = PS_SKID;
                end else if (outFire) begin
                    mainDrop  = 1'b1;
                    stateNext = PS_EMPTY;
                end
            end
            PS_SKID: begin
                if (outFire) begin
                    mainLoad     = 1'b1;
                    mainLoadData = skidData;
                    skidDrop     = 1'b1;
                    stateNext    = PS_FULL;
                end
            end
            default: stateNext = PS_EMPTY;
        endcase
    end

    pipe_slot #(.DATA_W(DATA_W), .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)) skidSlot (
        .clk(clk), .rst(rst), .flush(flush),
        .load(skidLoad), .drop(skidDrop), .loadData(in_data),
        .valid(skidValid), .data(skidData)
    );
`else
    assign in_ready  = ~rst & ~stall & (~mainValid | out_ready);
    assign occupancy = {1'b0, mainValid};

    always_comb begin
        stateNext    = stateReg;
        mainLoad     = 1'b0;
        mainDrop     = 1'b0;
        mainLoadData = in_data;
        case (stateReg)
            PS_EMPTY: begin
                if (inFire) begin
                    mainLoad  = 1'b1;
                    stateNext = PS_FULL;
                end
            end
            PS_FULL: begin
                if (inFire) begin
                    mainLoad = 1'b1;
                end else if (outFire) begin
                    mainDrop  = 1'b1;
                    stateNext = PS_EMPTY;
                end
            end
            default: stateNext = PS_EMPTY;
        endcase
    end
`endif

    // Stall forces both fires low, so the FSM holds without an explicit term.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stateReg <= PS_EMPTY;
        end else begin
            stateReg <= stateNext;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: directed scenarios then random traffic against a queue model.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, stall, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, inReadyNc, outValidNc;
    logic [31:0] out_data, outDataNc;
    logic [1:0]  occupancy, occupancyNc;

    int checks = 0;
    int errors = 0;

    // Model: held entries in order; mainD/mainDNc mirror the visible main payload.
    logic [31:0] q[$];
    logic [31:0] mainD, mainDNc;
    bit          modelLive = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1'b0)) dutNc (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(inReadyNc), .in_data(in_data),
        .out_valid(outValidNc), .out_ready(out_ready), .out_data(outDataNc),
        .occupancy(occupancyNc)
    );

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic s, input logic iv,
                        input logic [31:0] d, input logic orr);
        logic expInReady, expOutValid, inFireM, outFireM;
        rst = r; flush = f; stall = s; in_valid = iv; in_data = d; out_ready = orr;
        @(negedge clk);
        if (CAP == 2) expInReady = !r && !s && (q.size() < 2);
        else          expInReady = !r && !s && (q.size() == 0 || orr);
        expOutValid = !s && (q.size() > 0);
        if (r || modelLive) begin
            checkEq("in_ready", {63'd0, in_ready}, {63'd0, expInReady});
            checkEq("in_ready_nc", {63'd0, inReadyNc}, {63'd0, expInReady});
        end
        if (!r && modelLive) begin
            checkEq("out_valid", {63'd0, out_valid}, {63'd0, expOutValid});
            checkEq("out_data", {32'd0, out_data}, {32'd0, mainD});
            checkEq("out_data_nc", {32'd0, outDataNc}, {32'd0, mainDNc});
            checkEq("occupancy", {62'd0, occupancy}, 64'(q.size()));
        end
        if (r) begin
            q.delete();
            mainD = '0;
            mainDNc = '0;
            modelLive = 1'b1;
        end else if (modelLive) begin
            inFireM  = iv && expInReady;
            outFireM = expOutValid && orr;
            if (outFireM) $display("XFER out data=%08h flush=%0b", q[0], f);
            if (f) begin
                q.delete();
                mainD = '0;
            end else begin
                if (outFireM) void'(q.pop_front());
                if (inFireM) q.push_back(d);
                if (q.size() > 0) begin
                    mainD = q[0];
                    mainDNc = q[0];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        mainD = '0; mainDNc = '0;
        // Reset with live input offered
        step(1, 0, 0, 1, 32'hDEADBEEF, 0);
        step(1, 0, 0, 1, 32'hDEADBEEF, 0);
        // Streaming
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 32'(i), 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // Backpressure
        step(0, 0, 0, 1, 32'hA, 0);
        step(0, 0, 0, 1, 32'hB, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        // Stall
        step(0, 0, 0, 1, 32'h55, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'h66, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // Flush with simultaneous input
        step(0, 0, 0, 1, 32'h11, 0);
        step(0, 0, 0, 1, 32'h22, 0);
        step(0, 1, 0, 1, 32'h77, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // Payload retention on flush (visible on the non-clearing instance)
        step(0, 0, 0, 1, 32'h1234, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(99) < 2, $urandom_range(99) < 5, $urandom_range(99) < 10,
                 $urandom_range(99) < 70, $urandom, $urandom_range(99) < 65);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
